// File: rtl/nes_bus_pkg.sv
`default_nettype none
// ============================================================================
// Package     : nes_bus_pkg
// Description : Shared definitions for the CPU-side memory bus: arbiter state
//               encoding, address decode constants and idle-bus levels.
// Revision    : 1.0 - initial release
// ============================================================================
package nes_bus_pkg;

  // Arbiter state encoding
  typedef enum logic [2:0] {
    ST_CPU      = 3'd0,  // CPU owns the bus
    ST_DRAIN    = 3'd1,  // CPU halted, letting its in-flight access finish
    ST_GNT_IDLE = 3'd2,  // HCI granted, bus idle, waiting for a strobe
    ST_ACC      = 3'd3,  // single HCI access cycle
    ST_WAIT     = 3'd4,  // waiting for slave read data
    ST_RETURN   = 3'd5   // grant dropped, one idle cycle before the CPU resumes
  } arb_state_e;

  // Address decode: the slave is chosen by address bits [15:13]
  localparam int unsigned REGION_LSB = 13;
  localparam int unsigned PRG_BIT    = 15;
  localparam logic [2:0]  WRAM_SEL   = 3'b000;
  localparam logic [2:0]  PPU_SEL    = 3'b001;

  // Levels presented while no access is in progress
  localparam logic IDLE_PRG_NCE = 1'b1;
  localparam logic IDLE_WRAM_EN = 1'b0;
  localparam logic IDLE_PPU_NCS = 1'b1;
  localparam logic IDLE_R_NW    = 1'b1;

endpackage
`default_nettype wire

// File: rtl/cpumc_addr_decode.sv
`default_nettype none
// ============================================================================
// Module      : cpumc_addr_decode
// Description : Combinational slave-enable decode for the CPU-side bus. Any
//               bus requester can reuse it; force_idle_in parks all slaves.
// Ports       : region_in      - address bits [15:13] of the bus address
//               force_idle_in  - 1 = no access in progress, deselect all
//               prg_nce_out    - cart PRG enable, active-low
//               wram_en_out    - WRAM enable, active-high
//               ppu_ncs_out    - PPU register select, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module cpumc_addr_decode
  import nes_bus_pkg::*;
(
  input  logic [2:0] region_in,
  input  logic       force_idle_in,
  output logic       prg_nce_out,
  output logic       wram_en_out,
  output logic       ppu_ncs_out
);

  localparam int unsigned PRG_IDX = PRG_BIT - REGION_LSB;

  always_comb begin
    if (force_idle_in) begin
      prg_nce_out = IDLE_PRG_NCE;
      wram_en_out = IDLE_WRAM_EN;
      ppu_ncs_out = IDLE_PPU_NCS;
    end else begin
      prg_nce_out = ~region_in[PRG_IDX];
      wram_en_out = (region_in == WRAM_SEL);
      ppu_ncs_out = ~(region_in == PPU_SEL);
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpumc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cpumc_arbiter
// Description : Owns the CPU-side memory bus (cart PRG, WRAM, PPU registers)
//               and shares it between the CPU and the HCI debug block. The
//               CPU is halted through rdy, drained, then HCI performs single
//               accesses with a fixed read latency. Slaves are held idle
//               whenever no access is in progress.
// Ports       : clk_in, rst_in               - clock, async active-high reset
//               cpu_a/r_nw/d_in, cpu_rdy_out - CPU side, cpu_d_out read data
//               hci_req_in / hci_gnt_out     - bus request / grant handshake
//               hci_a/r_nw/d_in, strobe_in   - HCI access request
//               hci_ack_out, hci_d_out       - access done, captured read data
//               bus_a/r_nw/d_out, bus_d_in   - shared bus
//               prg_nce/wram_en/ppu_ncs_out  - slave enables
// Revision    : 1.0 - initial release
// ============================================================================
module cpumc_arbiter
  import nes_bus_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned RD_LATENCY   = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] cpu_a_in,
  input  logic        cpu_r_nw_in,
  input  logic [7:0]  cpu_d_in,
  output logic        cpu_rdy_out,
  output logic [7:0]  cpu_d_out,
  input  logic        hci_req_in,
  output logic        hci_gnt_out,
  input  logic [15:0] hci_a_in,
  input  logic        hci_r_nw_in,
  input  logic [7:0]  hci_d_in,
  input  logic        hci_strobe_in,
  output logic        hci_ack_out,
  output logic [7:0]  hci_d_out,
  output logic [15:0] bus_a_out,
  output logic        bus_r_nw_out,
  output logic [7:0]  bus_d_out,
  input  logic [7:0]  bus_d_in,
  output logic        prg_nce_out,
  output logic        wram_en_out,
  output logic        ppu_ncs_out
);

  // One counter serves both DRAIN and WAIT; it counts 0 .. N-1.
  localparam int unsigned CNT_MAX = (DRAIN_CYCLES > RD_LATENCY) ? DRAIN_CYCLES : RD_LATENCY;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(RD_LATENCY - 1);

  arb_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              cpu_rdy_q;
  logic              hci_gnt_q;
  logic              hci_ack_q;
  logic [7:0]        hci_rdata_q;
  logic [15:0]       lat_a_q;
  logic              lat_r_nw_q;
  logic [7:0]        lat_d_q;

  // Bus source selection
  logic [15:0] bus_a;
  logic        bus_r_nw;
  logic [7:0]  bus_wd;
  logic        force_idle;

  always_comb begin
    bus_a      = lat_a_q;
    bus_r_nw   = IDLE_R_NW;
    bus_wd     = 8'h00;
    force_idle = 1'b1;
    case (state_q)
      // The CPU keeps the bus while draining so its last access completes.
      ST_CPU, ST_DRAIN: begin
        bus_a      = cpu_a_in;
        bus_r_nw   = cpu_r_nw_in;
        bus_wd     = cpu_d_in;
        force_idle = 1'b0;
      end
      // Address is shown to the bus but no slave is selected.
      ST_GNT_IDLE: begin
        bus_a = hci_a_in;
      end
      ST_ACC: begin
        bus_r_nw   = lat_r_nw_q;
        bus_wd     = lat_d_q;
        force_idle = 1'b0;
      end
      default: begin
      end
    endcase
  end

  cpumc_addr_decode u_decode (
    .region_in     (bus_a[15:REGION_LSB]),
    .force_idle_in (force_idle),
    .prg_nce_out   (prg_nce_out),
    .wram_en_out   (wram_en_out),
    .ppu_ncs_out   (ppu_ncs_out)
  );

  // Arbiter FSM with registered handshake outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= ST_CPU;
      cnt_q       <= '0;
      cpu_rdy_q   <= 1'b1;
      hci_gnt_q   <= 1'b0;
      hci_ack_q   <= 1'b0;
      hci_rdata_q <= 8'h00;
      lat_a_q     <= 16'h0000;
      lat_r_nw_q  <= 1'b1;
      lat_d_q     <= 8'h00;
    end else begin
      hci_ack_q <= 1'b0;
      case (state_q)
        ST_CPU: begin
          if (hci_req_in) begin
            state_q   <= ST_DRAIN;
            cnt_q     <= '0;
            cpu_rdy_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!hci_req_in) begin
            state_q <= ST_RETURN;
          end else if (cnt_q == DRAIN_LAST) begin
            state_q   <= ST_GNT_IDLE;
            hci_gnt_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_GNT_IDLE: begin
          // A strobe wins over a simultaneous request drop.
          if (hci_strobe_in) begin
            state_q    <= ST_ACC;
            lat_a_q    <= hci_a_in;
            lat_r_nw_q <= hci_r_nw_in;
            lat_d_q    <= hci_d_in;
          end else if (!hci_req_in) begin
            state_q   <= ST_RETURN;
            hci_gnt_q <= 1'b0;
          end
        end
        ST_ACC: begin
          state_q <= ST_WAIT;
          cnt_q   <= '0;
        end
        ST_WAIT: begin
          if (cnt_q == WAIT_LAST) begin
            state_q   <= ST_GNT_IDLE;
            hci_ack_q <= 1'b1;
            if (lat_r_nw_q) begin
              hci_rdata_q <= bus_d_in;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RETURN: begin
          state_q   <= ST_CPU;
          cpu_rdy_q <= 1'b1;
        end
        default: begin
          state_q   <= ST_CPU;
          cpu_rdy_q <= 1'b1;
          hci_gnt_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_rdy_out  = cpu_rdy_q;
  assign cpu_d_out    = bus_d_in;
  assign hci_gnt_out  = hci_gnt_q;
  assign hci_ack_out  = hci_ack_q;
  assign hci_d_out    = hci_rdata_q;
  assign bus_a_out    = bus_a;
  assign bus_r_nw_out = bus_r_nw;
  assign bus_d_out    = bus_wd;

endmodule
`default_nettype wire

// File: tb/tb_cpumc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpumc_arbiter
// Description : Directed self-checking bench for cpumc_arbiter with a
//               synchronous slave model and an HCI read-data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpumc_arbiter;

  localparam int DRAIN = 2;
  localparam int RDL   = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_a;
  logic        cpu_r_nw;
  logic [7:0]  cpu_d;
  logic        cpu_rdy;
  logic [7:0]  cpu_rd;
  logic        hci_req;
  logic        hci_gnt;
  logic [15:0] hci_a;
  logic        hci_r_nw;
  logic [7:0]  hci_d;
  logic        hci_strobe;
  logic        hci_ack;
  logic [7:0]  hci_rd;
  logic [15:0] bus_a;
  logic        bus_r_nw;
  logic [7:0]  bus_wd;
  logic [7:0]  bus_d_in;
  logic        prg_nce;
  logic        wram_en;
  logic        ppu_ncs;

  always #5 clk = ~clk;

  cpumc_arbiter #(.DRAIN_CYCLES(DRAIN), .RD_LATENCY(RDL)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .cpu_a_in      (cpu_a),
    .cpu_r_nw_in   (cpu_r_nw),
    .cpu_d_in      (cpu_d),
    .cpu_rdy_out   (cpu_rdy),
    .cpu_d_out     (cpu_rd),
    .hci_req_in    (hci_req),
    .hci_gnt_out   (hci_gnt),
    .hci_a_in      (hci_a),
    .hci_r_nw_in   (hci_r_nw),
    .hci_d_in      (hci_d),
    .hci_strobe_in (hci_strobe),
    .hci_ack_out   (hci_ack),
    .hci_d_out     (hci_rd),
    .bus_a_out     (bus_a),
    .bus_r_nw_out  (bus_r_nw),
    .bus_d_out     (bus_wd),
    .bus_d_in      (bus_d_in),
    .prg_nce_out   (prg_nce),
    .wram_en_out   (wram_en),
    .ppu_ncs_out   (ppu_ncs)
  );

  function automatic logic [7:0] slave_f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h96;
  endfunction

  // Slave model: synchronous read data one cycle after a selected read
  logic        sel;
  logic        ovr_en = 1'b0;
  logic [7:0]  ovr_d  = 8'h00;
  logic [7:0]  slave_q = 8'h00;
  logic        rd_pend = 1'b0;
  logic [15:0] rd_addr = 16'h0000;
  int          ppu_cnt = 0;
  int          sel_cnt = 0;
  int          wr_cnt  = 0;
  int          ack_cnt = 0;
  logic [15:0] last_wr_a = 16'h0000;
  logic [7:0]  last_wr_d = 8'h00;

  assign sel      = !prg_nce || wram_en || !ppu_ncs;
  assign bus_d_in = ovr_en ? ovr_d : slave_q;

  always @(negedge clk) begin
    if (!ppu_ncs) ppu_cnt <= ppu_cnt + 1;
    if (sel)      sel_cnt <= sel_cnt + 1;
    if (hci_ack)  ack_cnt <= ack_cnt + 1;
    if (sel && !bus_r_nw) begin
      wr_cnt    <= wr_cnt + 1;
      last_wr_a <= bus_a;
      last_wr_d <= bus_wd;
    end
    rd_pend <= sel && bus_r_nw;
    rd_addr <= bus_a;
  end

  always @(posedge clk) slave_q <= rd_pend ? slave_f(rd_addr) : 8'h00;

  // Scoreboard of expected hci_d_out at each ack
  logic [7:0] exp_q[$];
  logic [7:0] model_rdata = 8'h00;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt();
    int n = 0;
    while (n < 16) begin
      next_cycle();
      n++;
      if (hci_gnt) break;
    end
    chk("gnt_latency", n, DRAIN + 1);
  endtask

  // Issue one HCI access from GNT_IDLE; returns in the ack cycle.
  task automatic hci_access(input logic rnw, input logic [15:0] a, input logic [7:0] d,
                            input bit strobe_in_wait, input bit drop_req);
    int lat;
    hci_a = a; hci_r_nw = rnw; hci_d = d; hci_strobe = 1'b1;
    if (rnw) model_rdata = slave_f(a);
    exp_q.push_back(model_rdata);
    next_cycle();
    hci_strobe = 1'b0; hci_a = ~a; hci_d = ~d; hci_r_nw = ~rnw;
    if (drop_req) hci_req = 1'b0;
    #1;
    chk("acc_addr", bus_a, a);
    chk("acc_rnw", bus_r_nw, rnw);
    if (!rnw) chk("acc_wdata", bus_wd, d);
    chk("acc_gnt", hci_gnt, 1'b1);
    lat = 0;
    while (lat < 8) begin
      next_cycle();
      lat++;
      hci_strobe = (strobe_in_wait && lat == 1);
      #1;
      if (hci_ack) break;
    end
    hci_strobe = 1'b0;
    hci_r_nw = 1'b1;
    chk("ack_latency", lat, 1 + RDL);
    if (exp_q.size() > 0) chk("hci_rdata", hci_rd, exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, s0, a0, w0;
    rst = 1'b1;
    cpu_a = 16'h0123; cpu_r_nw = 1'b1; cpu_d = 8'h00;
    hci_req = 1'b0; hci_a = 16'h0000; hci_r_nw = 1'b1; hci_d = 8'h00; hci_strobe = 1'b0;

    // Reset values
    next_cycle();
    next_cycle();
    chk("rst_rdy", cpu_rdy, 1'b1);
    chk("rst_gnt", hci_gnt, 1'b0);
    chk("rst_ack", hci_ack, 1'b0);
    chk("rst_rdata", hci_rd, 8'h00);
    rst = 1'b0;

    // CPU read of WRAM, data passes straight through
    next_cycle();
    ovr_en = 1'b1; ovr_d = 8'h5A;
    #1;
    chk("cpu_bus_a", bus_a, 16'h0123);
    chk("cpu_wram_en", wram_en, 1'b1);
    chk("cpu_prg_nce", prg_nce, 1'b1);
    chk("cpu_ppu_ncs", ppu_ncs, 1'b1);
    chk("cpu_rdata", cpu_rd, 8'h5A);
    chk("cpu_rdy", cpu_rdy, 1'b1);
    cpu_a = 16'hC000;
    #1;
    chk("cpu_prg_sel", prg_nce, 1'b0);
    chk("cpu_prg_wram", wram_en, 1'b0);
    cpu_a = 16'h0123; ovr_en = 1'b0;

    // Request, drain, grant timing
    next_cycle();
    hci_req = 1'b1; hci_a = 16'h2002;
    #1;
    chk("c0_rdy", cpu_rdy, 1'b1);
    next_cycle();
    chk("c1_rdy", cpu_rdy, 1'b0);
    chk("c1_gnt", hci_gnt, 1'b0);
    chk("c1_bus_cpu", bus_a, 16'h0123);
    chk("c1_wram", wram_en, 1'b1);
    next_cycle();
    chk("c2_gnt", hci_gnt, 1'b0);
    next_cycle();
    chk("c3_gnt", hci_gnt, 1'b1);
    chk("c3_rdy", cpu_rdy, 1'b0);
    chk("idle_bus_a", bus_a, 16'h2002);
    chk("idle_ppu", ppu_ncs, 1'b1);
    chk("idle_prg", prg_nce, 1'b1);
    chk("idle_wram", wram_en, 1'b0);
    chk("idle_rnw", bus_r_nw, 1'b1);

    // HCI read of a PPU register
    p0 = ppu_cnt;
    hci_access(1'b1, 16'h2002, 8'h00, 1'b0, 1'b0);
    next_cycle();
    chk("ack_single", hci_ack, 1'b0);
    chk("gnt_held", hci_gnt, 1'b1);
    chk("ppu_once", ppu_cnt - p0, 1);

    // HCI write to PRG, then release the bus
    w0 = wr_cnt;
    hci_access(1'b0, 16'h8000, 8'hA5, 1'b0, 1'b0);
    chk("wr_count", wr_cnt - w0, 1);
    chk("wr_addr", last_wr_a, 16'h8000);
    chk("wr_data", last_wr_d, 8'hA5);
    hci_req = 1'b0;
    next_cycle();
    chk("ret_gnt", hci_gnt, 1'b0);
    chk("ret_rdy", cpu_rdy, 1'b0);
    chk("ret_wram", wram_en, 1'b0);
    chk("ret_rnw", bus_r_nw, 1'b1);
    next_cycle();
    chk("back_rdy", cpu_rdy, 1'b1);
    chk("back_bus", bus_a, 16'h0123);
    chk("back_wram", wram_en, 1'b1);

    // Ignored strobes: without grant, and during WAIT; request dropped in ACC
    cpu_a = 16'h4000;
    a0 = ack_cnt;
    hci_a = 16'h2002; hci_strobe = 1'b1;
    next_cycle();
    hci_strobe = 1'b0;
    #1;
    chk("nognt_gnt", hci_gnt, 1'b0);
    chk("nognt_rdy", cpu_rdy, 1'b1);
    chk("nognt_ppu", ppu_ncs, 1'b1);
    hci_req = 1'b1;
    wait_gnt();
    s0 = sel_cnt;
    hci_access(1'b1, 16'h0010, 8'h00, 1'b1, 1'b1);
    next_cycle();
    chk("drop_ret_gnt", hci_gnt, 1'b0);
    chk("drop_ret_rdy", cpu_rdy, 1'b0);
    next_cycle();
    chk("drop_cpu_rdy", cpu_rdy, 1'b1);
    next_cycle();
    chk("one_access", sel_cnt - s0, 1);
    chk("one_ack", ack_cnt - a0, 1);

    // Reset in the middle of WAIT
    hci_req = 1'b1;
    wait_gnt();
    a0 = ack_cnt;
    hci_a = 16'h2002; hci_r_nw = 1'b1; hci_strobe = 1'b1;
    next_cycle();
    hci_strobe = 1'b0;
    next_cycle();
    rst = 1'b1;
    #1;
    chk("rstw_gnt", hci_gnt, 1'b0);
    chk("rstw_rdy", cpu_rdy, 1'b1);
    chk("rstw_rdata", hci_rd, 8'h00);
    model_rdata = 8'h00;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      chk("rsth_rdy", cpu_rdy, 1'b1);
      chk("rsth_gnt", hci_gnt, 1'b0);
      chk("rsth_ack", hci_ack, 1'b0);
    end
    hci_req = 1'b0;
    rst = 1'b0;
    next_cycle();
    chk("rstw_noack", ack_cnt - a0, 0);

    // Write strobe coincident with reset is dropped
    hci_req = 1'b1;
    wait_gnt();
    w0 = wr_cnt;
    hci_a = 16'h0030; hci_r_nw = 1'b0; hci_d = 8'h77; hci_strobe = 1'b1;
    rst = 1'b1;
    #1;
    chk("rsts_gnt", hci_gnt, 1'b0);
    next_cycle();
    hci_strobe = 1'b0; hci_r_nw = 1'b1; hci_req = 1'b0;
    next_cycle();
    rst = 1'b0;
    next_cycle();
    chk("rsts_nowr", wr_cnt - w0, 0);
    chk("rsts_rdy", cpu_rdy, 1'b1);
    chk("rsts_bus", bus_a, 16'h4000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
